// File: rtl/verilog_bus_fifo.sv
// First-word fall-through register FIFO with occupancy flags and count.
// Define VERILOG_BUS_FIFO_OVERFLOW_EN to enable the sticky overflow flag.
module verilog_bus_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty,
    output logic                    overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push_c, pop_c;

    // Handshakes, pointer advance (DEPTH is a power of two so pointers wrap naturally)
    always_comb begin
        push_c   = in_valid & ~full_q;
        pop_c    = out_ready & ~empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage is intentionally not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign in_ready  = ~full_q;
    assign out_valid = ~empty_q;
    assign count     = count_q;
    assign full      = full_q;
    assign empty     = empty_q;

`ifdef VERILOG_BUS_FIFO_OVERFLOW_EN
    logic overflow_q;

    // Sticky: any word offered while full is lost, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (in_valid & full_q) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_verilog_bus_fifo.sv
// Self-checking bench for verilog_bus_fifo: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_verilog_bus_fifo;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned DEPTH = 4;

`ifdef VERILOG_BUS_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready = 1'b0;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    logic [WIDTH-1:0] model_q[$];
    bit               model_ovf = 1'b0;

    verilog_bus_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most DEPTH words
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            bit do_push;
            bit do_pop;
            do_push = in_valid && (model_q.size() < DEPTH);
            do_pop  = out_ready && (model_q.size() > 0);
            if (in_valid && model_q.size() == DEPTH) model_ovf = 1'b1;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(in_data);
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk("count", 32'(count), 32'(model_q.size()));
            chk("full", 32'(full), 32'(model_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(model_q.size() == 0));
            chk("in_ready", 32'(in_ready), 32'(model_q.size() != DEPTH));
            chk("out_valid", 32'(out_valid), 32'(model_q.size() != 0));
            chk("overflow", 32'(overflow), 32'(OVF_EN && model_ovf));
            if (model_q.size() > 0) chk("out_data", 32'(out_data), 32'(model_q[0]));
        end
    end

    // Drive one cycle of inputs at a falling edge and wait for the next falling edge
    task automatic cyc(input logic iv, input logic [WIDTH-1:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(negedge clk);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Fill to full
        cyc(1'b1, 4'h1, 1'b0);
        chk("fill1_count", 32'(count), 32'd1);
        chk("fill1_data", 32'(out_data), 32'h1);
        cyc(1'b1, 4'h2, 1'b0);
        chk("fill2_count", 32'(count), 32'd2);
        cyc(1'b1, 4'h3, 1'b0);
        chk("fill3_count", 32'(count), 32'd3);
        cyc(1'b1, 4'h4, 1'b0);
        chk("fill4_count", 32'(count), 32'd4);
        chk("fill4_full", 32'(full), 32'd1);
        chk("fill4_in_ready", 32'(in_ready), 32'd0);
        chk("fill4_data", 32'(out_data), 32'h1);

        // Overflow attempt while full
        cyc(1'b1, 4'hF, 1'b0);
        chk("ovf_count", 32'(count), 32'd4);
        chk("ovf_data", 32'(out_data), 32'h1);
        chk("ovf_flag", 32'(overflow), 32'(OVF_EN));

        // Drain to empty
        cyc(1'b0, 4'h0, 1'b1);
        chk("drain_d2", 32'(out_data), 32'h2);
        cyc(1'b0, 4'h0, 1'b1);
        chk("drain_d3", 32'(out_data), 32'h3);
        cyc(1'b0, 4'h0, 1'b1);
        chk("drain_d4", 32'(out_data), 32'h4);
        cyc(1'b0, 4'h0, 1'b1);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_out_valid", 32'(out_valid), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'(OVF_EN));
        cyc(1'b0, 4'h0, 1'b1);
        chk("pop_empty_count", 32'(count), 32'd0);

        // Pointer wrap with count held at 1
        cyc(1'b1, 4'h0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            chk("wrap_head", 32'(out_data), 32'(i - 1));
            cyc(1'b1, 4'(i), 1'b1);
            chk("wrap_count", 32'(count), 32'd1);
        end
        chk("wrap_last", 32'(out_data), 32'h9);
        cyc(1'b0, 4'h0, 1'b1);
        chk("wrap_empty", 32'(empty), 32'd1);

        // Full with simultaneous push and pop: only the pop happens
        cyc(1'b1, 4'hB, 1'b0);
        cyc(1'b1, 4'hC, 1'b0);
        cyc(1'b1, 4'hD, 1'b0);
        cyc(1'b1, 4'hE, 1'b0);
        chk("fullpp_pre", 32'(count), 32'd4);
        cyc(1'b1, 4'h7, 1'b1);
        chk("fullpp_count", 32'(count), 32'd3);
        chk("fullpp_in_ready", 32'(in_ready), 32'd1);
        chk("fullpp_data", 32'(out_data), 32'hC);

        // Reset pulse between edges with count=3
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        chk("midrst_overflow", 32'(overflow), 32'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cyc(1'b1, 4'hA, 1'b0);
        chk("postrst_valid", 32'(out_valid), 32'd1);
        chk("postrst_data", 32'(out_data), 32'hA);
        chk("postrst_count", 32'(count), 32'd1);

        // Randomized traffic: push-heavy, pop-heavy, then balanced
        for (int ph = 0; ph < 3; ph++) begin
            for (int n = 0; n < 200; n++) begin
                int pv;
                int pr;
                pv = (ph == 0) ? 80 : (ph == 1) ? 25 : 50;
                pr = (ph == 0) ? 25 : (ph == 1) ? 80 : 50;
                cyc(1'($urandom_range(0, 99) < pv), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 99) < pr));
            end
        end
        cyc(1'b0, 4'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
